// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM state, buffered fetch entry, opcode field bounds.
// No logic; no latency; no backpressure.
// Imported by fetch_ctrl and fetch_buf2.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of fetched {inst, pc}; head is read straight from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller pushes only when count<2 or popping; flush empties it in one cycle.
module fetch_buf2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot [2];
    logic         rd_ptr;
    logic         wr_ptr;

    assign head = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full with a pop, wr_ptr==rd_ptr: the head is read this cycle and overwritten at the edge.
            if (push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational imem, buffers two words for decode.
// Latency: first fetch the cycle after start is sampled; inst_valid one cycle after each fetch.
// Backpressure: fetch stalls (pc and im_addr held) while the buffer is full and decode is not accepting.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 8,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic [31:0]      fetch_pc,
    output logic             halted,
    output logic             busy
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    logic         is_halt;
    logic [31:0]  redirect_target;
    fetch_entry_t head;

    assign im_addr         = pc[IM_AW+1:2];
    assign fetch_pc        = pc;
    assign redirect_target = redirect_pc & ~32'h3;
    assign is_halt         = (im_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OP);

    // inst_valid comes only from registered count, so no combinational ready-through.
    assign inst_valid = (count != 2'd0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (push && is_halt) state_nxt = HALT;
            HALT:    if (redirect_valid) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        halted = (state == HALT);
        pop    = inst_valid && inst_ready;
        push   = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_target;
        else if (push)           pc <= pc + 32'd4;
    end

    fetch_buf2 u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{inst: im_rdata, pc: pc}),
        .count (count),
        .head  (head)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-ported, combinational instruction memory (256 x 32-bit words).
- Owns the PC and drives the memory word index each cycle.
- Captures fetched words and their PCs into a 2-entry buffer, presented to decode over a valid/ready handshake.
- Handles start, back-pressure, branch/jump redirect with flush, and halt-on-opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IM_AW, 8, memory word-index width (depth 2^IM_AW).
- HALT_OP, 6'h3F, opcode (bits 31:26) that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE and begins fetching.
- im_addr  out  IM_AW  word index to instruction memory; equals pc[IM_AW+1:2].
- im_rdata  in  32  instruction word, combinationally valid in the same cycle as im_addr.
- redirect_valid  in  1  one-cycle pulse from execute: branch/jump taken.
- redirect_pc  in  32  redirect target byte address; bits 1:0 are ignored and forced to 0.
- inst_valid  out  1  buffer head valid.
- inst  out  32  buffer head instruction.
- inst_pc  out  32  byte PC of buffer head.
- inst_ready  in  1  decode accepts head.
- fetch_pc  out  32  current PC register.
- halted  out  1  high in HALT state.
- busy  out  1  high in RUN state.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low; all state is cleared on assertion.
- Reset values:
  - pc=RESET_PC; state=IDLE; count=0.
  - inst_valid=0, inst=0, inst_pc=0, halted=0, busy=0.
  - im_addr tracks pc combinationally.
- States (2-bit, encodings IDLE=0, RUN=1, HALT=2):
  - IDLE: no fetch. start -> RUN next edge.
  - RUN: fetch when push allowed.
  - HALT: no fetch. redirect_valid -> RUN (pc<=redirect_pc); start is ignored.
- Push condition: state==RUN && !redirect_valid && (count<2 || pop).
  - On push, enqueue {im_rdata, pc} at tail and set pc<=pc+4.
  - pc wraps modulo 2^32; im_addr therefore wraps modulo 2^IM_AW words.
- Pop: inst_valid && inst_ready. Head advances. Combinational ready-through is not allowed; inst_valid depends only on registered count.
- Push and pop in the same cycle: count is unchanged.
- Full (count==2) with no pop: pc holds, no memory word is consumed, im_addr is stable.
- Empty: inst_valid=0; inst and inst_pc hold their last values (don't-care).
- Halt: a pushed word with im_rdata[31:26]==HALT_OP is enqueued normally, then state->HALT and pc holds at the halt PC+4. Decode still receives the halt word; buffered entries drain normally in HALT.
- Redirect (any state):
  - Buffer flushed (count<=0); no push that cycle.
  - pc<={redirect_pc[31:2],2'b00}.
  - inst_valid=0 from the next cycle; a pop in the redirect cycle is still honoured.
  - In IDLE: pc is loaded, state stays IDLE.
  - In RUN: state stays RUN.
  - In HALT: state -> RUN.
- Redirect and start in the same cycle in IDLE: pc<=redirect target and state->RUN.
- Latency: the first fetch occurs the cycle after start is sampled; inst_valid rises the following cycle. With inst_ready held high, the sustained rate is 1 instr/cycle.
- Reset mid-operation: immediate return to reset values; buffer contents are discarded.

Decomposition:
- Shared package fetch_pkg:
  - state enum fetch_state_t {IDLE, RUN, HALT}.
  - struct fetch_entry_t {inst[31:0], pc[31:0]}.
  - OPCODE_MSB/LSB constants (31/26).
- One natural sub-module, fetch_buf2: 2-entry FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count, head.

Test Plan:
- Reset release with start=0 for 5 cycles -> inst_valid=0, fetch_pc=0, im_addr=0. Then start=1 with inst_ready=1 and memory words 0..3 = 0x20010001.. -> inst_pc sequence 0,4,8,12 on consecutive cycles, inst matches the memory words.
- inst_ready=0 from the start of fetch -> after 2 pushes count=2, fetch_pc=8, im_addr=2 held stable. Raise inst_ready -> entries pc 0, 4, 8 delivered in order, none dropped or duplicated.
- redirect_valid with redirect_pc=0x0000_0043 while 2 entries buffered -> next cycle inst_valid=0, fetch_pc=0x40, im_addr=0x10. Next valid inst_pc=0x40.
- Memory word at index 3 = 0xFC000000 -> instructions at 0,4,8,12 delivered, then halted=1, fetch_pc=16, no further fetch. Subsequent redirect to 0 -> busy=1, fetch restarts at 0.
- PC wrap: redirect to 0x3FC -> im_addr=0xFF, then fetch_pc=0x400, im_addr=0x00; inst_pc values 0x3FC, 0x400.
- rst_n asserted mid-stream, asynchronously between clock edges -> outputs go to reset values immediately without a clock edge. After release, state=IDLE and fetch_pc=0.
